ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_pkg.sv | 41 ++++
 rtl/ps2_key_decoder_rx.sv | 85 ++++++++
 rtl/ps2_key_decoder.sv | 83 ++++++++
 tb/tb_ps2_key_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scancode constants, receiver state encoding and key mapping for the PS/2 key decoder.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_START,
        KEY_UP,
        KEY_DOWN
    } key_e;

    // Arrow codes are only meaningful behind an E0 prefix; letter/Enter codes only without it.
    function automatic key_e map_key(input logic ext, input logic [7:0] code);
        key_e k;
        k = KEY_NONE;
        if (ext) begin
            if (code == SC_UP)        k = KEY_UP;
            else if (code == SC_DOWN) k = KEY_DOWN;
        end else begin
            if (code == SC_ENTER)     k = KEY_START;
            else if (code == SC_W)    k = KEY_UP;
            else if (code == SC_S)    k = KEY_DOWN;
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, framing FSM, odd parity and timeout.
module ps2_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev;
    rx_state_e     state, state_n;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] timer;
    logic          fall, din, timed_out;

    assign fall      = clk_prev & ~clk_sync[1];
    assign din       = data_sync[1];
    assign timed_out = (state != RX_IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign rx_byte   = shift;

    // byte_valid/err are combinational so the decoder's registered outputs land one cycle after the stop edge.
    always_comb begin
        state_n    = state;
        byte_valid = 1'b0;
        err        = 1'b0;
        if (timed_out) begin
            state_n = RX_IDLE;
            err     = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (din) err = 1'b1; else state_n = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_n = RX_PARITY;
                RX_PARITY: state_n = RX_STOP;
                RX_STOP: begin
                    state_n = RX_IDLE;
                    if (din && (^{shift, parity_bit})) byte_valid = 1'b1;
                    else                               err        = 1'b1;
                end
                default:   state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= RX_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            timer      <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
            state     <= state_n;
            if (state == RX_IDLE || fall || timed_out) timer <= '0;
            else                                       timer <= timer + TW'(1);
            if (fall) begin
                case (state)
                    RX_IDLE:   bit_cnt <= '0;
                    RX_DATA: begin
                        shift   <= {din, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= din;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns received PS/2 bytes into one-shot game-control pulses, tracking E0/F0 prefixes and typematic hold.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40000
) (
    input  logic pclk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic start_pulse,
    output logic up_pulse,
    output logic down_pulse,
    output logic controller_burst,
    output logic frame_err
);
    logic [7:0] rx_byte;
    logic       byte_valid, rx_err;
    logic       ext, brk;
    logic       held_start, held_up, held_down;
    key_e       key;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .pclk       (pclk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .err        (rx_err)
    );

    assign key = map_key(ext, rx_byte);

    always_ff @(posedge pclk) begin
        if (rst) begin
            start_pulse      <= 1'b0;
            up_pulse         <= 1'b0;
            down_pulse       <= 1'b0;
            controller_burst <= 1'b0;
            frame_err        <= 1'b0;
            ext              <= 1'b0;
            brk              <= 1'b0;
            held_start       <= 1'b0;
            held_up          <= 1'b0;
            held_down        <= 1'b0;
        end else begin
            start_pulse      <= 1'b0;
            up_pulse         <= 1'b0;
            down_pulse       <= 1'b0;
            controller_burst <= byte_valid;
            frame_err        <= rx_err;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == SC_EXT)      ext <= 1'b1;
                else if (rx_byte == SC_BRK) brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    // A make sets held (pulsing only on its first make); a break clears it silently.
                    case (key)
                        KEY_START: begin
                            held_start  <= !brk;
                            start_pulse <= !brk && !held_start;
                        end
                        KEY_UP: begin
                            held_up  <= !brk;
                            up_pulse <= !brk && !held_up;
                        end
                        KEY_DOWN: begin
                            held_down  <= !brk;
                            down_pulse <= !brk && !held_down;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table, hand-written corner sequences, random frames vs model.
module tb_ps2_key_decoder;
    localparam int TO = 300;

    logic pclk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic start_pulse, up_pulse, down_pulse, controller_burst, frame_err;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk             (pclk),
        .rst              (rst),
        .ps2_clk          (ps2_clk),
        .ps2_data         (ps2_data),
        .start_pulse      (start_pulse),
        .up_pulse         (up_pulse),
        .down_pulse       (down_pulse),
        .controller_burst (controller_burst),
        .frame_err        (frame_err)
    );

    always #5 pclk = ~pclk;

    int checks = 0, failures = 0;
    int n_start = 0, n_up = 0, n_down = 0, n_burst = 0, n_err = 0, multi_key = 0;
    int s_start, s_up, s_down, s_burst, s_err;

    always @(negedge pclk) begin
        if (start_pulse)      n_start <= n_start + 1;
        if (up_pulse)         n_up    <= n_up + 1;
        if (down_pulse)       n_down  <= n_down + 1;
        if (controller_burst) n_burst <= n_burst + 1;
        if (frame_err)        n_err   <= n_err + 1;
        if (int'(start_pulse) + int'(up_pulse) + int'(down_pulse) > 1) multi_key <= multi_key + 1;
    end

    typedef struct {
        logic [7:0] code;
        int         bad;   // 0 good, 1 bad parity, 2 bad stop
        int         es, eu, ed, eb, ee;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [7:0] c, input int bad, input int es, eu, ed, eb, ee);
        vec_t v;
        v.code = c; v.bad = bad; v.es = es; v.eu = eu; v.ed = ed; v.eb = eb; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic snap();
        s_start = n_start; s_up = n_up; s_down = n_down; s_burst = n_burst; s_err = n_err;
    endtask

    task automatic check_frame(input string name, input int es, eu, ed, eb, ee);
        int gs, gu, gd, gb, ge;
        gs = n_start - s_start; gu = n_up - s_up; gd = n_down - s_down;
        gb = n_burst - s_burst; ge = n_err - s_err;
        checks++;
        if (gs != es || gu != eu || gd != ed || gb != eb || ge != ee) begin
            failures++;
            $display("FAIL %s: got start/up/down/burst/err=%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                     name, gs, gu, gd, gb, ge, es, eu, ed, eb, ee);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge pclk); ps2_data = b;
        repeat (4) @(negedge pclk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge pclk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ (bad == 1));
        send_bit(bad != 2);
        repeat (4) @(negedge pclk);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    // Reference model state: prefix flags and per-key held bits (1 start, 2 up, 3 down).
    bit m_ext, m_brk;
    bit m_held[4];
    int keymap[bit [8:0]];

    initial begin
        logic [7:0] pool[8];
        logic [7:0] lat_b;
        int k_seen;

        // ---------------- vector table ----------------
        add(8'hE0, 0, 0,0,0,1,0); add(8'h75, 0, 0,1,0,1,0);   // first up-arrow make
        add(8'hE0, 0, 0,0,0,1,0); add(8'h75, 0, 0,0,0,1,0);   // typematic repeat
        add(8'hE0, 0, 0,0,0,1,0); add(8'hF0, 0, 0,0,0,1,0); add(8'h75, 0, 0,0,0,1,0); // break
        add(8'hE0, 0, 0,0,0,1,0); add(8'h75, 0, 0,1,0,1,0);   // make again
        add(8'h1C, 0, 0,0,0,1,0); add(8'h75, 0, 0,0,0,1,0);   // unmapped / 75 without E0
        add(8'h1B, 1, 0,0,0,0,1); add(8'h1B, 0, 0,0,1,1,0);   // bad parity then good S
        add(8'h5A, 0, 1,0,0,1,0); add(8'h5A, 0, 0,0,0,1,0);
        add(8'hF0, 0, 0,0,0,1,0); add(8'h5A, 0, 0,0,0,1,0); add(8'h5A, 0, 1,0,0,1,0);
        add(8'hE0, 0, 0,0,0,1,0); add(8'h1D, 2, 0,0,0,0,1);   // bad stop clears ext
        add(8'h72, 0, 0,0,0,1,0);                              // no E0 any more -> unmapped
        add(8'h1D, 0, 0,0,0,1,0);                              // W shares held up bit
        add(8'hF0, 0, 0,0,0,1,0); add(8'h1D, 0, 0,0,0,1,0);
        add(8'hE0, 0, 0,0,0,1,0); add(8'h75, 0, 0,1,0,1,0);
        add(8'hE0, 0, 0,0,0,1,0); add(8'h72, 0, 0,0,0,1,0);   // down already held via S
        add(8'hE0, 0, 0,0,0,1,0); add(8'hE0, 0, 0,0,0,1,0); add(8'h72, 0, 0,0,0,1,0);

        // ---------------- reset state ----------------
        repeat (2) @(negedge pclk);
        for (int i = 0; i < 5; i++) begin
            ps2_clk = i[0]; ps2_data = 1'b0;
            repeat (3) @(negedge pclk);
            chk($sformatf("reset_outputs_%0d", i),
                {27'd0, start_pulse, up_pulse, down_pulse, controller_burst, frame_err}, 0);
        end
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            snap();
            send_frame(tbl[i].code, tbl[i].bad);
            check_frame($sformatf("vec%0d_%02h", i, tbl[i].code),
                        tbl[i].es, tbl[i].eu, tbl[i].ed, tbl[i].eb, tbl[i].ee);
        end

        // ---------------- Enter latency after the stop edge ----------------
        do_reset();
        lat_b = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(lat_b[i]);
        send_bit(1'b1);
        @(negedge pclk); ps2_data = 1'b1;
        repeat (4) @(negedge pclk);
        ps2_clk = 1'b0;
        @(negedge pclk);
        chk("lat_sync1", {30'd0, start_pulse, controller_burst}, 0);
        @(negedge pclk);
        chk("lat_detect", {30'd0, start_pulse, controller_burst}, 0);
        @(negedge pclk);
        chk("lat_pulse", {27'd0, start_pulse, up_pulse, down_pulse, controller_burst, frame_err}, 5'b10010);
        @(negedge pclk);
        chk("lat_one_cycle", {30'd0, start_pulse, controller_burst}, 0);
        repeat (5) @(negedge pclk);
        ps2_clk = 1'b1;
        repeat (8) @(negedge pclk);

        // ---------------- timeout mid-frame ----------------
        do_reset();
        snap();
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        k_seen = -1;
        for (int k = 0; k < TO + 40; k++) begin
            @(negedge pclk);
            if (n_err != s_err) begin k_seen = k; break; end
        end
        check_frame("timeout_err", 0, 0, 0, 0, 1);
        checks++;
        if (k_seen < TO - 12 || k_seen > TO - 8) begin
            failures++;
            $display("FAIL timeout_delay: got %0d cycles expected %0d..%0d", k_seen, TO - 12, TO - 8);
        end
        snap();
        send_frame(8'h5A, 0);
        check_frame("after_timeout_5A", 1, 0, 0, 1, 0);

        // ---------------- reset mid-frame ----------------
        do_reset();
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(negedge pclk); rst = 1'b1;
        @(negedge pclk); rst = 1'b0;
        repeat (30) @(negedge pclk);
        check_frame("rst_abort_quiet", 0, 0, 0, 0, 0);
        snap();
        send_frame(8'hE0, 0);
        send_frame(8'h72, 0);
        check_frame("after_rst_E0_72", 0, 0, 1, 2, 0);

        // ---------------- randomized frames vs reference model ----------------
        keymap[{1'b0, 8'h5A}] = 1; keymap[{1'b0, 8'h1D}] = 2; keymap[{1'b0, 8'h1B}] = 3;
        keymap[{1'b1, 8'h75}] = 2; keymap[{1'b1, 8'h72}] = 3;
        pool = '{8'hE0, 8'hF0, 8'h5A, 8'h75, 8'h72, 8'h1D, 8'h1B, 8'h1C};
        do_reset();
        m_ext = 0; m_brk = 0;
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        for (int n = 0; n < 70; n++) begin
            int idx, bad, key;
            int e[4];
            logic [7:0] c;
            idx = $urandom_range(0, 9);
            c   = (idx > 7) ? 8'($urandom_range(0, 255)) : pool[idx];
            bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            for (int j = 0; j < 4; j++) e[j] = 0;
            if (bad != 0) begin
                m_ext = 0; m_brk = 0;
            end else if (c == 8'hE0) m_ext = 1;
            else if (c == 8'hF0)     m_brk = 1;
            else begin
                key = keymap.exists({m_ext, c}) ? keymap[{m_ext, c}] : 0;
                if (key != 0) begin
                    if (m_brk) m_held[key] = 0;
                    else begin
                        if (!m_held[key]) e[key] = 1;
                        m_held[key] = 1;
                    end
                end
                m_ext = 0; m_brk = 0;
            end
            snap();
            send_frame(c, bad);
            check_frame($sformatf("rand%0d_%02h_bad%0d", n, c, bad),
                        e[1], e[2], e[3], (bad == 0) ? 1 : 0, (bad != 0) ? 1 : 0);
        end

        chk("one_key_pulse_per_cycle", multi_key, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
